counter: RTL and testbench

Free-running, parameter-width binary up-counter with synchronous active-low reset. Increments by one on every rising clock edge and wraps modulo 2^SIZE. Used as a generic timebase or sequence source; its output feeds downstream logic directly as a registered value.

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_wrap_det.sv | 26 ++
 rtl/counter.sv | 48 ++++
 tb/tb_counter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter block: default/maximum widths
// and the all-ones terminal value used for wrap detection.
package counter_pkg;

  localparam int unsigned COUNTER_DEFAULT_SIZE = 4;
  localparam int unsigned COUNTER_MAX_SIZE     = 32;

  // All-ones value of a given width; the last count before wrapping to zero.
  function automatic longint unsigned terminal_value(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/counter_wrap_det.sv
// Registered wrap pulse: high for the one cycle in which count has just wrapped
// from all-ones to zero. Only instantiated when COUNTER_OVF_EN is defined.
module counter_wrap_det
  import counter_pkg::*;
#(
  parameter int unsigned SIZE = COUNTER_DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] count,
  output logic            ovf
);

  localparam logic [SIZE-1:0] TERM = SIZE'(terminal_value(SIZE));

  // Set on the same edge that takes count from TERM to zero; a reset load of
  // zero never raises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= (count == TERM);
    end
  end

endmodule

// File: rtl/counter.sv
// Free-running SIZE-bit up-counter with synchronous active-low reset to RST_VAL.
// Define COUNTER_OVF_EN to add the registered wrap pulse output ovf.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned       SIZE    = COUNTER_DEFAULT_SIZE,
  parameter longint unsigned   RST_VAL = 0
) (
  input  logic            clk,
  input  logic            rst,
`ifdef COUNTER_OVF_EN
  output logic            ovf,
`endif
  output logic [SIZE-1:0] count
);

  if ((SIZE < 1) || (SIZE > COUNTER_MAX_SIZE)) begin : g_bad_size
    $fatal(1, "counter: SIZE=%0d outside 1..%0d", SIZE, COUNTER_MAX_SIZE);
  end

  if (RST_VAL > terminal_value(SIZE)) begin : g_bad_rst_val
    $fatal(1, "counter: RST_VAL=%0d does not fit in %0d bits", RST_VAL, SIZE);
  end

  localparam logic [SIZE-1:0] RST_LOAD = SIZE'(RST_VAL);
  localparam logic [SIZE-1:0] ONE      = SIZE'(1);

  // Carry out of the MSB is dropped, giving modulo 2^SIZE wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= RST_LOAD;
    end else begin
      count <= count + ONE;
    end
  end

`ifdef COUNTER_OVF_EN
  counter_wrap_det #(
    .SIZE (SIZE)
  ) u_wrap_det (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .ovf   (ovf)
  );
`endif

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default width, SIZE=1, and SIZE=8 with RST_VAL=250,
// all sharing one clock and reset. ovf checks are active under COUNTER_OVF_EN.
module tb_counter;

  logic       clk;
  logic       rst;
  logic [3:0] count4;
  logic [0:0] count1;
  logic [7:0] count8;
`ifdef COUNTER_OVF_EN
  logic       ovf4;
  logic       ovf1;
  logic       ovf8;
`endif

  int checks;
  int failures;

  counter u_dut4 (
    .clk   (clk),
    .rst   (rst),
`ifdef COUNTER_OVF_EN
    .ovf   (ovf4),
`endif
    .count (count4)
  );

  counter #(.SIZE(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
`ifdef COUNTER_OVF_EN
    .ovf   (ovf1),
`endif
    .count (count1)
  );

  counter #(.SIZE(8), .RST_VAL(250)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
`ifdef COUNTER_OVF_EN
    .ovf   (ovf8),
`endif
    .count (count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;

    // Reset hold: four edges with rst low.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_hold_c4", 64'(count4), 64'd0);
      chk("rst_hold_c1", 64'(count1), 64'd0);
      chk("rst_hold_c8", 64'(count8), 64'd250);
`ifdef COUNTER_OVF_EN
      chk("rst_hold_ovf4", 64'(ovf4), 64'd0);
      chk("rst_hold_ovf8", 64'(ovf8), 64'd0);
`endif
    end

    // Release and count 15 edges; SIZE=1 toggles, SIZE=8 wraps on edge 6.
    rst = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("run_c4", 64'(count4), 64'(k));
      chk("run_c1", 64'(count1), 64'(k % 2));
      chk("run_c8", 64'(count8), 64'((250 + k) % 256));
`ifdef COUNTER_OVF_EN
      chk("run_ovf4", 64'(ovf4), 64'd0);
      chk("run_ovf1", 64'(ovf1), 64'(k % 2 == 0));
      chk("run_ovf8", 64'(ovf8), 64'(k == 6));
`endif
    end

    // Wrap of the default-width counter.
    step();
    chk("wrap_c4_zero", 64'(count4), 64'd0);
`ifdef COUNTER_OVF_EN
    chk("wrap_ovf4_set", 64'(ovf4), 64'd1);
`endif
    step();
    chk("wrap_c4_one", 64'(count4), 64'd1);
`ifdef COUNTER_OVF_EN
    chk("wrap_ovf4_clr", 64'(ovf4), 64'd0);
`endif

    // Advance to 7, then reset for exactly one edge.
    for (int i = 0; i < 6; i++) step();
    chk("mid_c4_pre", 64'(count4), 64'd7);
    rst = 1'b0;
    step();
    chk("mid_rst_c4", 64'(count4), 64'd0);
    chk("mid_rst_c8", 64'(count8), 64'd250);
    chk("mid_rst_c1", 64'(count1), 64'd0);
`ifdef COUNTER_OVF_EN
    chk("mid_rst_ovf4", 64'(ovf4), 64'd0);
`endif
    rst = 1'b1;
    step();
    chk("mid_rel_c4", 64'(count4), 64'd1);
    chk("mid_rel_c8", 64'(count8), 64'd251);

    // rst glitch that never covers a rising edge.
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    step();
    chk("glitch_c4_a", 64'(count4), 64'd2);
    chk("glitch_c8_a", 64'(count8), 64'd252);
    #3 rst = 1'b0;
    #2 rst = 1'b1;
    step();
    chk("glitch_c4_b", 64'(count4), 64'd3);
    chk("glitch_c1_b", 64'(count1), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "tb_counter watchdog expired");
  end

endmodule
